// File: rtl/text_fetch_ctrl.sv
// Character-cell text front end: prefetches one glyph row per 8-pixel cell from
// a shared single-port VRAM and hands every cycle the scan-out does not need to a host writer.
module text_fetch_ctrl #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        host_req,
  input  logic [11:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic        host_ack,
  output logic [11:0] vram_addr,
  output logic        vram_we,
  output logic [7:0]  vram_wdata,
  input  logic [7:0]  vram_rdata,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic        pixel_on
);

  localparam logic [11:0] CELLS     = 12'(COLS * ROWS);
  localparam logic [7:0]  COLS_W    = 8'(COLS);
  localparam logic [9:0]  ACT_PIX   = 10'(COLS * 8);
  localparam logic [9:0]  ACT_LINES = 10'(ROWS * 16);
  localparam logic [9:0]  LAST_X    = 10'd792;
  localparam logic [9:0]  LAST_Y    = 10'd524;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_VGA_RD  = 2'd1,
    ST_HOST_WR = 2'd2
  } arb_state_t;

  arb_state_t  state_s;
  arb_state_t  state_r;
  logic [2:0]  phase_s;
  logic [7:0]  tgt_col_s;
  logic [9:0]  tgt_line_s;
  logic        fetch_s;
  logic        vga_slot_s;
  logic        active_s;

  logic [7:0]  code_r;
  logic [3:0]  font_line_r;
  logic        code_vld_r;
  logic [7:0]  next_row_r;
  logic        row_vld_r;
  logic [7:0]  shift_r;
  logic        pixel_on_r;

  function automatic logic [11:0] cell_addr(input logic [9:0] line, input logic [7:0] col);
    logic [11:0] row_v;
    row_v = {6'd0, line[9:4]};
    return 12'(row_v * 12'(COLS)) + {4'd0, col};
  endfunction

  assign phase_s    = DrawX[2:0];
  assign fetch_s    = (tgt_col_s < COLS_W) && (tgt_line_s < ACT_LINES);
  assign vga_slot_s = fetch_s && ((phase_s == 3'd1) || (phase_s == 3'd2));
  assign active_s   = (DrawX < ACT_PIX) && (DrawY < ACT_LINES);

  // Target cell: the next cell on this line, or column 0 of the next line during the last cell.
  always_comb begin
    tgt_col_s  = 8'd0;
    tgt_line_s = 10'd0;
    if (DrawX < LAST_X) begin
      tgt_col_s  = {1'b0, DrawX[9:3]} + 8'd1;
      tgt_line_s = DrawY;
    end else if (DrawY == LAST_Y) begin
      tgt_col_s  = 8'd0;
      tgt_line_s = 10'd0;
    end else begin
      tgt_col_s  = 8'd0;
      tgt_line_s = DrawY + 10'd1;
    end
  end

  // Arbiter grant for the current cycle; the host is answered in the cycle it is granted.
  always_comb begin
    state_s    = ST_IDLE;
    host_ack   = 1'b0;
    vram_we    = 1'b0;
    vram_addr  = 12'd0;
    vram_wdata = 8'd0;
    if (Reset) begin
      state_s = ST_IDLE;
    end else if (vga_slot_s) begin
      state_s = ST_VGA_RD;
    end else if (host_req) begin
      state_s = ST_HOST_WR;
    end else begin
      state_s = ST_IDLE;
    end
    case (state_s)
      ST_VGA_RD: begin
        vram_addr = cell_addr(tgt_line_s, tgt_col_s);
      end
      ST_HOST_WR: begin
        host_ack   = 1'b1;
        vram_we    = (host_addr < CELLS);
        vram_addr  = host_addr;
        vram_wdata = host_wdata;
      end
      ST_IDLE: begin
        vram_addr = 12'd0;
      end
      default: begin
        vram_addr = 12'd0;
      end
    endcase
  end

  // Previous grant: lets the phase-2 latch know the read address really went out last cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Glyph pipeline: code latch, font row latch, then the per-cell pixel shifter.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      code_r      <= 8'd0;
      font_line_r <= 4'd0;
      code_vld_r  <= 1'b0;
      next_row_r  <= 8'd0;
      row_vld_r   <= 1'b0;
      shift_r     <= 8'd0;
      pixel_on_r  <= 1'b0;
    end else begin
      if (phase_s == 3'd2) begin
        code_vld_r <= (state_r == ST_VGA_RD);
        if (state_r == ST_VGA_RD) begin
          code_r      <= vram_rdata;
          font_line_r <= tgt_line_s[3:0];
        end
      end
      if (phase_s == 3'd3) begin
        row_vld_r <= code_vld_r;
        if (code_vld_r) begin
          next_row_r <= font_data ^ {8{code_r[7]}};
        end
      end
      // Loading on the last phase makes pixel 0 of the new cell the MSB during phase 0.
      if (phase_s == 3'd7) begin
        shift_r <= row_vld_r ? next_row_r : 8'd0;
      end else begin
        shift_r <= {shift_r[6:0], 1'b0};
      end
      pixel_on_r <= shift_r[7] && active_s;
    end
  end

  assign font_addr = {code_r[6:0], font_line_r};
  assign pixel_on  = pixel_on_r;

endmodule

// File: tb/tb_text_fetch_ctrl.sv
// Randomized bench for text_fetch_ctrl: drives raster segments and host writes,
// predicting acks, fetch addresses and pixels from a cell/font reference model.
`timescale 1ns/1ps
module tb_text_fetch_ctrl;

  logic        Clk;
  logic        Reset;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        host_req;
  logic [11:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_ack;
  logic [11:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic        pixel_on;

  logic [7:0] vram_mem [0:4095];
  logic [7:0] ref_vram [0:4095];
  int         last_wr  [0:4095];
  bit         mem_ready;

  int n_checks;
  int n_errors;
  int cyc;
  int dx, dy, px, py, cont;
  bit hpend;
  int haddr, hdata, hidle;
  bit f037, f038, f040, seen037, seen038, seen040;
  int rst_hold;
  logic [7:0] init7;
  logic [15:0] a_row;

  text_fetch_ctrl dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .host_req(host_req), .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack),
    .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
    .font_addr(font_addr), .font_data(font_data), .pixel_on(pixel_on)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [7:0] font_rom(input logic [10:0] a);
    logic [7:0] v;
    if (a == {7'h41, 4'd0}) v = 8'h18;
    else v = 8'(({1'b0, a} * 12'd29) ^ ({1'b0, a} >> 3));
    return v;
  endfunction

  assign font_data = font_rom(font_addr);

  // VRAM: one port, read data one cycle after the address
  always @(posedge Clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 4096; i++) vram_mem[i] <= ref_vram[i];
      mem_ready <= 1'b1;
    end else if (vram_we) begin
      vram_mem[vram_addr] <= vram_wdata;
    end
    vram_rdata <= vram_mem[vram_addr];
  end

  function automatic bit is_vga_slot(int x, int y);
    int col, line;
    if (x < 792) begin col = x / 8 + 1; line = y; end
    else begin col = 0; line = (y + 1) % 525; end
    return (col < 80) && (line < 480) && ((x % 8) == 1 || (x % 8) == 2);
  endfunction

  function automatic int fetch_addr(int x, int y);
    int col, line;
    if (x < 792) begin col = x / 8 + 1; line = y; end
    else begin col = 0; line = (y + 1) % 525; end
    return (line / 16) * 80 + col;
  endfunction

  function automatic bit ref_pixel(int x, int y);
    logic [7:0] c, row;
    if (x >= 640 || y >= 480) return 1'b0;
    c   = ref_vram[(y / 16) * 80 + x / 8];
    row = font_rom({c[6:0], 4'(y % 16)});
    return row[7 - (x % 8)] ^ c[7];
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (x=%0d y=%0d cycle=%0d)", tag, got, exp, dx, dy, cyc);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ack"},    32'(host_ack),   32'd0);
    check_eq({tag, "_we"},     32'(vram_we),    32'd0);
    check_eq({tag, "_addr"},   32'(vram_addr),  32'd0);
    check_eq({tag, "_wdata"},  32'(vram_wdata), 32'd0);
    check_eq({tag, "_font"},   32'(font_addr),  32'd0);
    check_eq({tag, "_pixel"},  32'(pixel_on),   32'd0);
  endtask

  task automatic start_req(input int a, input int d);
    hpend = 1'b1;
    haddr = a;
    hdata = d;
  endtask

  task automatic run_cycle();
    bit    slot, dirty, exp_pix;
    string t;
    @(posedge Clk);
    #1;
    cyc++;
    if (rst_hold > 0) begin
      rst_hold--;
      if (rst_hold == 0) Reset = 1'b0;
    end
    px = dx;
    py = dy;
    if (dx == 799) begin dx = 0; dy = (dy == 524) ? 0 : dy + 1; end
    else dx++;
    cont++;
    if (!hpend && !Reset) begin
      if (dy == 100 && dx == 9 && !seen037) begin start_req(5, 8'h42); f037 = 1'b1; end
      else if (dy == 101 && dx == 9 && !seen038) begin start_req(2400, 8'h77); f038 = 1'b1; end
      else if (dy == 200 && dx == 9 && !seen040) begin start_req(7, 8'h5A); f040 = 1'b1; end
      else if (hidle > 0) hidle--;
      else if (dx >= 16) begin
        if ($urandom_range(0, 9) == 0) start_req($urandom_range(2400, 4095), $urandom_range(0, 255));
        else start_req($urandom_range(8, 2399), $urandom_range(0, 255));
      end
    end
    DrawX      = 10'(dx);
    DrawY      = 10'(dy);
    host_req   = hpend;
    host_addr  = 12'(haddr);
    host_wdata = 8'(hdata);
    if (f040 && hpend && dx == 10) begin
      #2;
      Reset = 1'b1;
      #1;
      check_reset_outputs("req040_async");
      hpend    = 1'b0;
      host_req = 1'b0;
      f040     = 1'b0;
      seen040  = 1'b1;
      rst_hold = 4;
    end
    @(negedge Clk);
    if (Reset) begin
      check_reset_outputs("reset");
      cont = 0;
    end else begin
      slot = is_vga_slot(dx, dy);
      if (hpend && !slot) begin
        t = "host_ack";
        if (f037) t = "req037_ack";
        if (f038) t = "req038_ack";
        check_eq(t, 32'(host_ack), 32'd1);
        t = f038 ? "req038_we" : "host_we";
        check_eq(t, 32'(vram_we), (haddr < 2400) ? 32'd1 : 32'd0);
        if (haddr < 2400) begin
          check_eq("host_addr", 32'(vram_addr), 32'(haddr));
          check_eq("host_wdata", 32'(vram_wdata), 32'(hdata));
          ref_vram[haddr] = 8'(hdata);
          last_wr[haddr]  = cyc;
        end
        if (f037) seen037 = 1'b1;
        if (f038) seen038 = 1'b1;
        f037  = 1'b0;
        f038  = 1'b0;
        hpend = 1'b0;
        hidle = $urandom_range(0, 4);
      end else begin
        t = hpend ? "stall_ack" : "idle_ack";
        check_eq(t, 32'(host_ack), 32'd0);
        check_eq("read_we", 32'(vram_we), 32'd0);
        if (slot && (dx % 8) == 1) begin
          t = (dy == 15 && dx == 793) ? "req039_addr" : "fetch_addr";
          check_eq(t, 32'(vram_addr), 32'(fetch_addr(dx, dy)));
        end
      end
      if (cont > 16) begin
        exp_pix = ref_pixel(px, py);
        dirty   = 1'b0;
        if (px < 640 && py < 480) dirty = (cyc - last_wr[(py / 16) * 80 + px / 8]) < 24;
        if (!dirty) check_eq("pixel_on", 32'(pixel_on), 32'(exp_pix));
        if (dy == 0 && dx >= 1 && dx <= 16) check_eq("req035_036_pix", 32'(pixel_on), 32'(a_row[16 - dx]));
      end
    end
  endtask

  initial begin
    int seg_y [10];
    int mism;
    n_checks = 0; n_errors = 0; cyc = 0; cont = 0;
    hpend = 1'b0; haddr = 0; hdata = 0; hidle = 0;
    a_row = 16'b0001_1000_1110_0111;
    for (int i = 0; i < 4096; i++) begin
      ref_vram[i] = 8'($urandom_range(0, 255));
      last_wr[i]  = -1000;
    end
    ref_vram[0] = 8'h41;
    ref_vram[1] = 8'hC1;
    init7 = ref_vram[7];
    Reset = 1'b0; DrawX = 10'd0; DrawY = 10'd0;
    host_req = 1'b0; host_addr = 12'd0; host_wdata = 8'd0;
    #2;
    Reset = 1'b1;
    #1;
    check_reset_outputs("por");
    dx = 700; dy = 0; rst_hold = 6;
    for (int i = 0; i < 12; i++) run_cycle();

    seg_y = '{524, 15, 99, 199, 300, 478, 522, 0, 0, 0};
    for (int s = 7; s < 10; s++) seg_y[s] = $urandom_range(0, 524);
    for (int s = 0; s < 10; s++) begin
      while (hpend) run_cycle();
      dx = 783; dy = seg_y[s]; cont = 0;
      for (int i = 0; i < 16 + 2 * 800; i++) run_cycle();
    end
    while (hpend) run_cycle();
    repeat (2) run_cycle();

    mism = 0;
    for (int i = 0; i < 4096; i++) if (vram_mem[i] !== ref_vram[i]) mism++;
    check_eq("vram_image", 32'(mism), 32'd0);
    check_eq("req037_mem", 32'(vram_mem[5]), 32'h42);
    check_eq("req040_nowrite", 32'(vram_mem[7]), 32'(init7));
    check_eq("req037_seen", 32'(seen037), 32'd1);
    check_eq("req038_seen", 32'(seen038), 32'd1);
    check_eq("req040_seen", 32'(seen040), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/text_fetch_ctrl.md
TEXT_FETCH_CTRL -- requirements
Module: text_fetch_ctrl

Interface
REQ-001 COLS, 80, character columns per screen.
REQ-002 ROWS, 30, character rows per screen.
REQ-003 Clk  input  1  pixel clock, one DrawX step per cycle; all state on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high; clears all state.
REQ-005 DrawX, DrawY  input  10 each  current scan position; 800x525 total, 640x480 active.
REQ-006 host_req  input  1  host write request; held with addr/data until host_ack.
REQ-007 host_addr  input  12  target cell index (row*COLS+col).
REQ-008 host_wdata  input  8  character code; bit 7 is the invert attribute, bits 6:0 the glyph.
REQ-009 host_ack  output  1  one-cycle pulse when the request is retired.
REQ-010 vram_addr  output  12  shared single-port VRAM address.
REQ-011 vram_we, vram_wdata  output  1, 8  VRAM write strobe and data.
REQ-012 vram_rdata  input  8  VRAM read data, valid one cycle after the address.
REQ-013 font_addr  output  11  {glyph[6:0], glyph row[3:0]} into the combinational font ROM.
REQ-014 font_data  input  8  font row; bit 7 is the leftmost pixel.
REQ-015 pixel_on  output  1  registered foreground flag for the colour mapper.

Function
REQ-016 Phase shall be DrawX[2:0]; each 8-pixel cell prefetches the glyph of the next cell ("target").
REQ-017 Target: col=DrawX[9:3]+1 and row line=DrawY for DrawX<792; for DrawX 792-799, col=0 and line=DrawY+1 (524 wraps to 0).
REQ-018 Fetch shall run only when the target col<COLS and line<480; otherwise the cell's fetch slots shall be host-eligible.
REQ-019 Phase 1: vram_addr=(line>>4)*COLS+col, vram_we=0 (VGA read slot).
REQ-020 Phase 2: latch vram_rdata into code_q.
REQ-021 Phase 3: drive font_addr={code_q[6:0], line[3:0]}; latch font_data XOR {8{code_q[7]}} into next_row.
REQ-022 Phase 0 (cell start): load next_row into an 8-bit shift register if that fetch ran, else load zero; otherwise shift left by one each cycle.
REQ-023 pixel_on shall be the registered shift-register MSB gated by active area: one-cycle latency, so the value visible at DrawX=x+1 is pixel x.
REQ-024 Arbiter states: IDLE, VGA_RD, HOST_WR.
REQ-025 VGA_RD shall occupy phases 1-2 whenever a fetch runs and shall take priority over the host.
REQ-026 HOST_WR shall be entered on any cycle with host_req=1 that is not a VGA slot: vram_we=1, vram_addr=host_addr, vram_wdata=host_wdata, host_ack=1 in that same cycle.
REQ-027 A request landing on a VGA slot shall stall and be served at the first free cycle; the worst-case wait is 2 cycles.
REQ-028 If host_addr >= COLS*ROWS (2400), the request shall be acked with vram_we=0.
REQ-029 Back-to-back requests: a new write may retire on the cycle after an ack.
REQ-030 Outside its slot, font_addr shall hold its last value.

Reset
REQ-031 While Reset=1: pixel_on=0, host_ack=0, vram_we=0, vram_addr=0, vram_wdata=0, font_addr=0, and the shift register, code_q and next_row are 0.
REQ-032 Arbiter state on reset shall be IDLE.
REQ-033 Reset during a pending request shall produce no ack or write; the host shall re-request.
REQ-034 Valid output resumes at the first full cell fetched after release.

Verification
REQ-035 VRAM cell 0=0x41, font row 0 of 'A'=0x18, DrawY=0 scan -> pixel_on=1 at DrawX=4,5 only within 1-8.
REQ-036 Cell 1=0xC1 (inverted 'A'), same row -> pixel_on at DrawX 9-16 = 1,1,1,0,0,1,1,1.
REQ-037 host_req at phase 1 in the active area, addr=5, data=0x42 -> vram_we/host_ack at phase 3, VRAM[5]=0x42.
REQ-038 host_req with addr=2400 -> host_ack one cycle, vram_we stays 0.
REQ-039 DrawX 792-799 on line 15 -> VGA read of addr 80 (row 1, col 0) at DrawX=793; pixel 0 of line 16 is correct.
REQ-040 Reset asserted between host_req and ack -> no ack, no write, all outputs 0 immediately (asynchronous).
